// File: rtl/mdu_sequencer_if.sv
// Bus between the E-stage and the multiply/divide sequencer.
// Request/ready: a transfer happens on a rising edge where start=1, kill=0 and busy=0; busy is the not-ready.
interface mdu_sequencer_if;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  MDUOp;
   logic        start;
   logic        kill;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDUOut;

   modport master (output A, B, MDUOp, start, kill,
                   input  busy, HI, LO, MDUOut);
   modport slave  (input  A, B, MDUOp, start, kill,
                   output busy, HI, LO, MDUOut);
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
// Results are computed from operands latched at accept and committed on the last busy edge.
module mdu_sequencer #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic              clk,
   input  logic              reset,
   mdu_sequencer_if.slave    bus,
   output logic [1:0]        dbg_state
);
   localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [3:0] OP_MULT  = 4'b0001;
   localparam logic [3:0] OP_MULTU = 4'b0010;
   localparam logic [3:0] OP_DIV   = 4'b0011;
   localparam logic [3:0] OP_DIVU  = 4'b0100;
   localparam logic [3:0] OP_MTHI  = 4'b0101;
   localparam logic [3:0] OP_MTLO  = 4'b0110;
   localparam logic [3:0] OP_MFHI  = 4'b0111;
   localparam logic [3:0] OP_MFLO  = 4'b1000;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [31:0]   hi_q, hi_nxt, lo_q, lo_nxt;
   logic [31:0]   a_q, b_q;
   logic [3:0]    op_q;
   logic          lat_en;

   // Datapath fed only by latched operands so upstream may change A/B freely while busy.
   logic          mul_sgn, div_sgn, a_neg, b_neg;
   logic [63:0]   a_ext, b_ext, prod;
   logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, div_q, div_r;

   always_comb begin
      mul_sgn = (op_q == OP_MULT);
      div_sgn = (op_q == OP_DIV);
      a_ext   = {{32{mul_sgn & a_q[31]}}, a_q};
      b_ext   = {{32{mul_sgn & b_q[31]}}, b_q};
      prod    = a_ext * b_ext;
      a_neg   = div_sgn & a_q[31];
      b_neg   = div_sgn & b_q[31];
      a_mag   = a_neg ? (32'd0 - a_q) : a_q;
      b_mag   = b_neg ? (32'd0 - b_q) : b_q;
      b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag   = a_mag / b_safe;
      r_mag   = a_mag % b_safe;
      div_q   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      div_r   = a_neg ? (32'd0 - r_mag) : r_mag;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      hi_nxt    = hi_q;
      lo_nxt    = lo_q;
      lat_en    = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start && !bus.kill) begin
               case (bus.MDUOp)
                  OP_MULT, OP_MULTU: begin
                     state_nxt = S_MUL;
                     cnt_nxt   = CW'(MUL_CYCLES);
                     lat_en    = 1'b1;
                  end
                  OP_DIV, OP_DIVU: begin
                     state_nxt = S_DIV;
                     cnt_nxt   = CW'(DIV_CYCLES);
                     lat_en    = 1'b1;
                  end
                  OP_MTHI: hi_nxt = bus.A;
                  OP_MTLO: lo_nxt = bus.A;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_nxt = S_IDLE;
               hi_nxt    = prod[63:32];
               lo_nxt    = prod[31:0];
            end
         end
         S_DIV: begin
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_nxt = S_IDLE;
               // Divide by zero burns the full latency but leaves HI/LO alone.
               if (b_q != 32'd0) begin
                  hi_nxt = div_r;
                  lo_nxt = div_q;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         hi_q  <= hi_nxt;
         lo_q  <= lo_nxt;
         if (lat_en) begin
            a_q  <= bus.A;
            b_q  <= bus.B;
            op_q <= bus.MDUOp;
         end
      end
   end

   assign bus.busy   = (state != S_IDLE);
   assign bus.HI     = hi_q;
   assign bus.LO     = lo_q;
   assign bus.MDUOut = (bus.MDUOp == OP_MFHI) ? hi_q :
                       (bus.MDUOp == OP_MFLO) ? lo_q : 32'd0;
   assign dbg_state  = state;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed table, multi-cycle corner sequences,
// then randomized ops scored against an arithmetic reference model.
module tb_mdu_sequencer;
   localparam int MULC = 5;
   localparam int DIVC = 10;

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;
   int         n_vec;
   int         n_err;
   logic [63:0] mdl;
   logic [63:0] exp_q[$];

   mdu_sequencer_if tif();

   mdu_sequencer #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (tif),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   vec_t vecs[13];

   // ---------------- reference model ----------------
   function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] old);
      longint sa, sb, q, r;
      longint unsigned ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         4'd1: return sa * sb;
         4'd2: return ua * ub;
         4'd3: begin
            if (b == 32'd0) return old;
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         4'd4: begin
            if (b == 32'd0) return old;
            return {32'(ua % ub), 32'(ua / ub)};
         end
         4'd5: return {a, old[31:0]};
         4'd6: return {old[63:32], a};
         default: return old;
      endcase
   endfunction

   function automatic int ref_cyc(input logic [3:0] op);
      if (op == 4'd1 || op == 4'd2) return MULC;
      if (op == 4'd3 || op == 4'd4) return DIVC;
      return 0;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_result(input string name, input logic [63:0] exp, input int exp_cyc,
                               input int cyc);
      check({name, " cycles"}, 64'(cyc), 64'(exp_cyc));
      check({name, " HI"}, {32'd0, tif.HI}, {32'd0, exp[63:32]});
      check({name, " LO"}, {32'd0, tif.LO}, {32'd0, exp[31:0]});
      check({name, " state"}, {62'd0, dbg_state}, 64'd0);
      tif.MDUOp = 4'b0111;
      #1 check({name, " mfhi"}, {32'd0, tif.MDUOut}, {32'd0, exp[63:32]});
      tif.MDUOp = 4'b1000;
      #1 check({name, " mflo"}, {32'd0, tif.MDUOut}, {32'd0, exp[31:0]});
      tif.MDUOp = 4'b0000;
      #1 check({name, " mdunone"}, {32'd0, tif.MDUOut}, 64'd0);
   endtask

   // ---------------- driver ----------------
   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (tif.busy && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   // Called at a negedge; presents one request for one edge, then scrambles inputs while busy.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic k, output int cyc);
      int c;
      tif.MDUOp = op;
      tif.A     = a;
      tif.B     = b;
      tif.start = 1'b1;
      tif.kill  = k;
      @(negedge clk);
      tif.start = 1'b0;
      tif.kill  = 1'b0;
      tif.MDUOp = 4'($urandom);
      tif.A     = $urandom;
      tif.B     = $urandom;
      wait_idle(c);
      cyc = c;
   endtask

   // ---------------- test ----------------
   initial begin
      int cyc;
      int c;
      logic [3:0]  op;
      logic [31:0] a, b;
      logic        k;
      logic [63:0] e;
      n_vec = 0;
      n_err = 0;
      vecs[0]  = '{4'h6, 32'h0000_1234, 32'h0,         32'h0000_0000, 32'h0000_1234, 0};
      vecs[1]  = '{4'h4, 32'h0000_0005, 32'h0,         32'h0000_0000, 32'h0000_1234, DIVC};
      vecs[2]  = '{4'h2, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE, MULC};
      vecs[3]  = '{4'h1, 32'hFFFF_FFFD, 32'h4,         32'hFFFF_FFFF, 32'hFFFF_FFF4, MULC};
      vecs[4]  = '{4'h3, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIVC};
      vecs[5]  = '{4'h3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIVC};
      vecs[6]  = '{4'h5, 32'hCAFE_BABE, 32'h0,         32'hCAFE_BABE, 32'h8000_0000, 0};
      vecs[7]  = '{4'h4, 32'h0000_0009, 32'h4,         32'h0000_0001, 32'h0000_0002, DIVC};
      vecs[8]  = '{4'h3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIVC};
      vecs[9]  = '{4'h3, 32'h0000_0005, 32'h0,         32'h0000_0001, 32'hFFFF_FFFD, DIVC};
      vecs[10] = '{4'h0, 32'h1111_1111, 32'h2,         32'h0000_0001, 32'hFFFF_FFFD, 0};
      vecs[11] = '{4'hF, 32'h2222_2222, 32'h3,         32'h0000_0001, 32'hFFFF_FFFD, 0};
      vecs[12] = '{4'h1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, MULC};

      reset = 1'b0;
      tif.A = '0; tif.B = '0; tif.MDUOp = '0; tif.start = 1'b0; tif.kill = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy", {63'd0, tif.busy}, 64'd0);
      check("reset HI", {32'd0, tif.HI}, 64'd0);
      check("reset LO", {32'd0, tif.LO}, 64'd0);
      check("reset state", {62'd0, dbg_state}, 64'd0);
      reset = 1'b1;

      // Directed table, issued back to back in the first idle cycle.
      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, cyc);
         check_result($sformatf("vec%0d", i), {vecs[i].hi, vecs[i].lo}, vecs[i].cyc, cyc);
      end
      mdl = {vecs[12].hi, vecs[12].lo};

      // mthi presented mid-multiply must be dropped.
      tif.MDUOp = 4'h1; tif.A = 32'd3; tif.B = 32'd5; tif.start = 1'b1;
      @(negedge clk);
      tif.start = 1'b0;
      check("busy_after_accept", {63'd0, tif.busy}, 64'd1);
      @(negedge clk);
      tif.MDUOp = 4'h5; tif.A = 32'hAA; tif.start = 1'b1;
      @(negedge clk);
      tif.start = 1'b0;
      wait_idle(c);
      mdl = 64'd15;
      check_result("mthi_in_busy", mdl, MULC, 2 + c);

      // Killed request is never accepted.
      tif.MDUOp = 4'h3; tif.A = 32'd100; tif.B = 32'd7; tif.start = 1'b1; tif.kill = 1'b1;
      @(negedge clk);
      tif.start = 1'b0; tif.kill = 1'b0;
      check("kill_busy", {63'd0, tif.busy}, 64'd0);
      check_result("kill_accept", mdl, 0, 0);

      // Kill pulse during a running multiply does not abort it.
      tif.MDUOp = 4'h2; tif.A = 32'h0001_0000; tif.B = 32'h0001_0000; tif.start = 1'b1;
      @(negedge clk);
      tif.start = 1'b0; tif.kill = 1'b1;
      @(negedge clk);
      tif.kill = 1'b0;
      wait_idle(c);
      mdl = 64'h0000_0001_0000_0000;
      check_result("kill_in_busy", mdl, MULC, 1 + c);

      // Asynchronous reset in the third divide cycle.
      tif.MDUOp = 4'h3; tif.A = 32'd1000; tif.B = 32'd3; tif.start = 1'b1;
      @(negedge clk);
      tif.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("arst busy", {63'd0, tif.busy}, 64'd0);
      check("arst HI", {32'd0, tif.HI}, 64'd0);
      check("arst LO", {32'd0, tif.LO}, 64'd0);
      check("arst state", {62'd0, dbg_state}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      run_op(4'h4, 32'd9, 32'd4, 1'b0, cyc);
      mdl = {32'd1, 32'd2};
      check_result("post_reset_divu", mdl, DIVC, cyc);

      // Randomized ops against the arithmetic model.
      for (int n = 0; n < 40; n++) begin
         op = 4'($urandom_range(1, 6));
         if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(7, 15));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 9));
            3: a = 32'hFFFF_FFFF;
            default: ;
         endcase
         k = ($urandom_range(0, 7) == 0);
         e = k ? mdl : ref_op(op, a, b, mdl);
         exp_q.push_back(e);
         run_op(op, a, b, k, cyc);
         mdl = exp_q.pop_front();
         check_result($sformatf("rnd%0d op%0h", n, op), mdl, k ? 0 : ref_cyc(op), cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
